jpeg_block_addr: RTL

Consumer-side partner of the MCU block-ID generator. Takes the decoded 8x8 pixel stream tagged with a 32-bit block ID {type[1:0], block_y[13:0], block_x[15:0]} and emits one raster coordinate, component and footprint per pixel. Sits between the IDCT/output stage and the frame-buffer writer. It clips pixels beyond the image edge and flags end of image when an EOF-type block ID arrives.

---
 rtl/jpeg_pkg.sv | 39 +++
 rtl/jpeg_block_addr_calc.sv | 48 ++++
 rtl/jpeg_block_addr.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG block-ID format used by the MCU-ID generator and
// the block-address consumer.
package jpeg_pkg;

    typedef enum logic [1:0] {
        FMT_MONO  = 2'd0,
        FMT_444   = 2'd1,
        FMT_420   = 2'd2,
        FMT_UNSUP = 2'd3
    } jpeg_format_e;

    typedef enum logic [1:0] {
        BLK_Y   = 2'd0,
        BLK_CB  = 2'd1,
        BLK_CR  = 2'd2,
        BLK_EOF = 2'd3
    } block_type_e;

    localparam int ID_TYPE_MSB = 31;
    localparam int ID_TYPE_LSB = 30;
    localparam int ID_Y_MSB    = 29;
    localparam int ID_Y_LSB    = 16;
    localparam int ID_X_MSB    = 15;
    localparam int ID_X_LSB    = 0;

    function automatic block_type_e id_type(input logic [31:0] id);
        return block_type_e'(id[ID_TYPE_MSB:ID_TYPE_LSB]);
    endfunction

    function automatic logic [15:0] id_bx(input logic [31:0] id);
        return id[ID_X_MSB:ID_X_LSB];
    endfunction

    // block_y is 14 bits wide; callers work in 16-bit coordinates
    function automatic logic [15:0] id_by(input logic [31:0] id);
        return {2'b00, id[ID_Y_MSB:ID_Y_LSB]};
    endfunction

endpackage

// File: rtl/jpeg_block_addr_calc.sv
// Combinational mapping of (block ID, pixel index, format) to a raster coordinate,
// footprint and keep/clip decision.
module jpeg_block_addr_calc
    import jpeg_pkg::*;
(
    input  logic [31:0]  id_i,
    input  logic [5:0]   idx_i,
    input  jpeg_format_e mode_i,
    input  logic [15:0]  width_i,
    input  logic [15:0]  height_i,
    output logic [15:0]  x_o,
    output logic [15:0]  y_o,
    output logic         scale_o,
    output block_type_e  type_o,
    output logic         keep_o
);

    logic [15:0] bx_s;
    logic [15:0] by_s;
    logic [15:0] col_s;
    logic [15:0] row_s;
    logic        chroma_s;

    // 4:2:0 chroma snaps to the even (MCU-aligned) block and spreads samples 2 apart
    always_comb begin
        type_o   = id_type(id_i);
        bx_s     = id_bx(id_i);
        by_s     = id_by(id_i);
        col_s    = {13'd0, idx_i[2:0]};
        row_s    = {13'd0, idx_i[5:3]};
        chroma_s = (type_o == BLK_CB) || (type_o == BLK_CR);
        x_o      = 16'd0;
        y_o      = 16'd0;
        scale_o  = 1'b0;
        if ((mode_i == FMT_420) && chroma_s) begin
            x_o     = ({bx_s[15:1], 1'b0} << 3) + (col_s << 1);
            y_o     = ({by_s[15:1], 1'b0} << 3) + (row_s << 1);
            scale_o = 1'b1;
        end else begin
            x_o     = (bx_s << 3) + col_s;
            y_o     = (by_s << 3) + row_s;
            scale_o = 1'b0;
        end
        keep_o = (mode_i != FMT_UNSUP) && (type_o != BLK_EOF) &&
                 (x_o < width_i) && (y_o < height_i);
    end

endmodule

// File: rtl/jpeg_block_addr.sv
// Block-ID consumer: walks each 8x8 block, emits one clipped raster coordinate per
// pixel through a single output register, and flags end of image.
module jpeg_block_addr
    import jpeg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        img_start_i,
    input  logic [15:0] img_width_i,
    input  logic [15:0] img_height_i,
    input  logic [1:0]  img_mode_i,
    input  logic        inport_valid_i,
    input  logic [7:0]  inport_data_i,
    input  logic [31:0] inport_id_i,
    output logic        inport_ready_o,
    output logic        outport_valid_o,
    output logic [7:0]  outport_data_o,
    output logic [15:0] outport_x_o,
    output logic [15:0] outport_y_o,
    output logic [1:0]  outport_type_o,
    output logic        outport_scale_o,
    input  logic        outport_ready_i,
    output logic        end_of_image_o,
    output logic        idle_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLOCK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e      state_r, state_next_s;
    logic [5:0]  idx_r, idx_next_s;
    logic [31:0] id_r, id_next_s;
    logic        out_valid_r, out_valid_next_s;
    logic [7:0]  out_data_r;
    logic [15:0] out_x_r, out_y_r;
    logic [1:0]  out_type_r;
    logic        out_scale_r;
    logic        eoi_r, eoi_next_s;
    logic        idle_r;

    logic [31:0] cur_id_s;
    logic        accept_s;
    logic        load_s;
    logic        is_eof_s;
    logic [15:0] calc_x_s, calc_y_s;
    logic        calc_scale_s, calc_keep_s;
    block_type_e calc_type_s;

    // beat 0 must see the live ID; the latch only becomes valid after that edge
    assign cur_id_s = (state_r == ST_IDLE) ? inport_id_i : id_r;

    jpeg_block_addr_calc u_calc (
        .id_i     (cur_id_s),
        .idx_i    (idx_r),
        .mode_i   (jpeg_format_e'(img_mode_i)),
        .width_i  (img_width_i),
        .height_i (img_height_i),
        .x_o      (calc_x_s),
        .y_o      (calc_y_s),
        .scale_o  (calc_scale_s),
        .type_o   (calc_type_s),
        .keep_o   (calc_keep_s)
    );

    assign inport_ready_o = !img_start_i &&
                            ((state_r == ST_DONE) || !out_valid_r || outport_ready_i);
    assign accept_s = inport_valid_i && inport_ready_o;
    assign is_eof_s = (calc_type_s == BLK_EOF);

    // next-state, counter, ID latch, output-valid and EOF flag
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        id_next_s        = id_r;
        eoi_next_s       = eoi_r;
        out_valid_next_s = out_valid_r;
        load_s           = 1'b0;
        if (img_start_i) begin
            state_next_s     = ST_IDLE;
            idx_next_s       = 6'd0;
            eoi_next_s       = 1'b0;
            out_valid_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_eof_s) begin
                        state_next_s = ST_DONE;
                        eoi_next_s   = 1'b1;
                    end else if (accept_s) begin
                        state_next_s = ST_BLOCK;
                        idx_next_s   = idx_r + 6'd1;
                        id_next_s    = inport_id_i;
                        load_s       = calc_keep_s;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BLOCK: begin
                    if (accept_s) begin
                        idx_next_s   = idx_r + 6'd1;
                        load_s       = calc_keep_s;
                        state_next_s = (idx_r == 6'd63) ? ST_IDLE : ST_BLOCK;
                    end else begin
                        state_next_s = ST_BLOCK;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = 6'd0;
                end
            endcase
            if (load_s) begin
                out_valid_next_s = 1'b1;
            end else if (outport_ready_i) begin
                out_valid_next_s = 1'b0;
            end else begin
                out_valid_next_s = out_valid_r;
            end
        end
    end

    // state and output registers; idle is registered from the next-state values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            idx_r       <= 6'd0;
            id_r        <= 32'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_x_r     <= 16'd0;
            out_y_r     <= 16'd0;
            out_type_r  <= 2'd0;
            out_scale_r <= 1'b0;
            eoi_r       <= 1'b0;
            idle_r      <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            id_r        <= id_next_s;
            out_valid_r <= out_valid_next_s;
            eoi_r       <= eoi_next_s;
            idle_r      <= (state_next_s != ST_BLOCK) && !out_valid_next_s;
            if (load_s) begin
                out_data_r  <= inport_data_i;
                out_x_r     <= calc_x_s;
                out_y_r     <= calc_y_s;
                out_type_r  <= calc_type_s;
                out_scale_r <= calc_scale_s;
            end
        end
    end

    assign outport_valid_o = out_valid_r;
    assign outport_data_o  = out_data_r;
    assign outport_x_o     = out_x_r;
    assign outport_y_o     = out_y_r;
    assign outport_type_o  = out_type_r;
    assign outport_scale_o = out_scale_r;
    assign end_of_image_o  = eoi_r;
    assign idle_o          = idle_r;

endmodule
